// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared types and default memory map for the APB interconnect
package apb_pkg;

    typedef enum logic [1:0] {
        FAULT_UNMAPPED = 2'd0,
        FAULT_SLVERR   = 2'd1,
        FAULT_TIMEOUT  = 2'd2,
        FAULT_PROTO    = 2'd3
    } fault_cause_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_t;

    localparam logic [31:0] SRAM_BASE   = 32'h8000_0000;
    localparam logic [31:0] SRAM_MASK   = 32'h8000_0000;
    localparam logic [31:0] UART_BASE   = 32'h1000_0000;
    localparam logic [31:0] UART_MASK   = 32'hFE00_0000;
    localparam logic [31:0] SYSTEM_BASE = 32'h0000_0000;
    localparam logic [31:0] SYSTEM_MASK = 32'hFFFF_0000;
    localparam logic [31:0] INTC_BASE   = 32'h2000_0000;
    localparam logic [31:0] INTC_MASK   = 32'hFFFF_FFFF;

    // Slave 0 sits in the lowest slice: SRAM=0, UART=1, SYSTEM=2, INTC=3.
    localparam logic [127:0] DEFAULT_SLAVE_BASE = {INTC_BASE, SYSTEM_BASE, UART_BASE, SRAM_BASE};
    localparam logic [127:0] DEFAULT_SLAVE_MASK = {INTC_MASK, SYSTEM_MASK, UART_MASK, SRAM_MASK};

endpackage

// File: rtl/apb_addr_decode.sv
// rtl/apb_addr_decode.sv - base/mask address match with lowest-index priority
module apb_addr_decode #(
    parameter int ADDR_WIDTH = 32,
    parameter int NUM_SLAVES = 4,
    parameter int IDX_W      = 2,
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_BASE = '0,
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_MASK = '0
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    output logic                  hit,
    output logic [IDX_W-1:0]      idx
);

    logic [ADDR_WIDTH-1:0] base_i;
    logic [ADDR_WIDTH-1:0] mask_i;

    // Scanning downwards lets the lowest matching index overwrite higher ones.
    always_comb begin
        hit    = 1'b0;
        idx    = '0;
        base_i = '0;
        mask_i = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            base_i = SLAVE_BASE[i*ADDR_WIDTH +: ADDR_WIDTH];
            mask_i = SLAVE_MASK[i*ADDR_WIDTH +: ADDR_WIDTH];
            if ((addr & mask_i) == (base_i & mask_i)) begin
                hit = 1'b1;
                idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/apb_interconnect.sv
// rtl/apb_interconnect.sv - APB router with latched decode, timeout watchdog and fault capture
module apb_interconnect
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_SLAVES     = 4,
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_BASE = DEFAULT_SLAVE_BASE,
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_MASK = DEFAULT_SLAVE_MASK,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                             pclk,
    input  logic                             rst,
    input  logic [ADDR_WIDTH-1:0]            paddr,
    input  logic                             psel,
    input  logic                             penable,
    output logic [DATA_WIDTH-1:0]            prdata,
    output logic                             pready,
    output logic                             perr,
    output logic [NUM_SLAVES-1:0]            s_sel,
    output logic [NUM_SLAVES-1:0]            s_enable,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] s_rdata,
    input  logic [NUM_SLAVES-1:0]            s_ready,
    input  logic [NUM_SLAVES-1:0]            s_perr,
    output logic                             fault_valid,
    output logic                             fault_overflow,
    output logic [ADDR_WIDTH-1:0]            fault_addr,
    output logic [1:0]                       fault_cause,
    input  logic                             fault_clear
);

    localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] TMO_VAL = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam bit TMO_EN = (TIMEOUT_CYCLES != 0);

    apb_state_t            state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  hit_q, hit_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    logic                  fault_valid_q, fault_valid_d;
    logic                  fault_overflow_q, fault_overflow_d;
    logic [ADDR_WIDTH-1:0] fault_addr_q, fault_addr_d;
    fault_cause_t          fault_cause_q, fault_cause_d;

    logic                  dec_hit;
    logic [IDX_W-1:0]      dec_idx;

    logic [NUM_SLAVES-1:0] sel_c, en_c;
    logic                  pready_c, perr_c;
    logic [DATA_WIDTH-1:0] prdata_c;
    logic                  ev_fault;
    fault_cause_t          ev_cause;
    logic [ADDR_WIDTH-1:0] ev_addr;

    apb_addr_decode #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_SLAVES (NUM_SLAVES),
        .IDX_W      (IDX_W),
        .SLAVE_BASE (SLAVE_BASE),
        .SLAVE_MASK (SLAVE_MASK)
    ) u_decode (
        .addr (paddr),
        .hit  (dec_hit),
        .idx  (dec_idx)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        hit_d    = hit_q;
        addr_d   = addr_q;
        cnt_d    = cnt_q;
        sel_c    = '0;
        en_c     = '0;
        pready_c = 1'b0;
        perr_c   = 1'b0;
        prdata_c = '0;
        ev_fault = 1'b0;
        ev_cause = FAULT_UNMAPPED;
        ev_addr  = addr_q;
        case (state_q)
            IDLE: begin
                if (psel && penable) begin
                    pready_c = 1'b1;
                    perr_c   = 1'b1;
                    ev_fault = 1'b1;
                    ev_cause = FAULT_PROTO;
                    ev_addr  = paddr;
                end else if (psel) begin
                    state_d = SETUP;
                end
            end
            SETUP: begin
                // Entered speculatively after a completion; a master that went idle aborts here.
                if (!psel) begin
                    state_d = IDLE;
                end else begin
                    if (dec_hit) sel_c[dec_idx] = 1'b1;
                    idx_d   = dec_idx;
                    hit_d   = dec_hit;
                    addr_d  = paddr;
                    cnt_d   = '0;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (!psel) begin
                    pready_c = 1'b1;
                    perr_c   = 1'b1;
                    ev_fault = 1'b1;
                    ev_cause = FAULT_PROTO;
                    ev_addr  = paddr;
                    state_d  = IDLE;
                end else if (!hit_q) begin
                    pready_c = 1'b1;
                    perr_c   = 1'b1;
                    ev_fault = 1'b1;
                    ev_cause = FAULT_UNMAPPED;
                    state_d  = SETUP;
                end else if (s_ready[idx_q]) begin
                    sel_c[idx_q] = 1'b1;
                    en_c[idx_q]  = penable;
                    pready_c     = 1'b1;
                    perr_c       = s_perr[idx_q];
                    prdata_c     = s_rdata[idx_q*DATA_WIDTH +: DATA_WIDTH];
                    ev_fault     = s_perr[idx_q];
                    ev_cause     = FAULT_SLVERR;
                    state_d      = SETUP;
                end else if (TMO_EN && (cnt_q == TMO_VAL)) begin
                    pready_c = 1'b1;
                    perr_c   = 1'b1;
                    ev_fault = 1'b1;
                    ev_cause = FAULT_TIMEOUT;
                    state_d  = SETUP;
                end else begin
                    sel_c[idx_q] = 1'b1;
                    en_c[idx_q]  = penable;
                    cnt_d        = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Clear is applied before capture so a same-cycle fault lands as a fresh first record.
    always_comb begin
        fault_valid_d    = fault_valid_q;
        fault_overflow_d = fault_overflow_q;
        fault_addr_d     = fault_addr_q;
        fault_cause_d    = fault_cause_q;
        if (fault_clear) begin
            fault_valid_d    = 1'b0;
            fault_overflow_d = 1'b0;
            fault_addr_d     = '0;
            fault_cause_d    = FAULT_UNMAPPED;
        end
        if (ev_fault) begin
            if (!fault_valid_d) begin
                fault_valid_d = 1'b1;
                fault_addr_d  = ev_addr;
                fault_cause_d = ev_cause;
            end else begin
                fault_overflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            state_q          <= IDLE;
            idx_q            <= '0;
            hit_q            <= 1'b0;
            addr_q           <= '0;
            cnt_q            <= '0;
            fault_valid_q    <= 1'b0;
            fault_overflow_q <= 1'b0;
            fault_addr_q     <= '0;
            fault_cause_q    <= FAULT_UNMAPPED;
        end else begin
            state_q          <= state_d;
            idx_q            <= idx_d;
            hit_q            <= hit_d;
            addr_q           <= addr_d;
            cnt_q            <= cnt_d;
            fault_valid_q    <= fault_valid_d;
            fault_overflow_q <= fault_overflow_d;
            fault_addr_q     <= fault_addr_d;
            fault_cause_q    <= fault_cause_d;
        end
    end

    // Gate with rst so slaves see sel fall immediately, even on the IDLE violation path.
    assign s_sel          = rst ? '0 : sel_c;
    assign s_enable       = rst ? '0 : en_c;
    assign pready         = rst ? 1'b0 : pready_c;
    assign perr           = rst ? 1'b0 : perr_c;
    assign prdata         = rst ? '0 : prdata_c;
    assign fault_valid    = fault_valid_q;
    assign fault_overflow = fault_overflow_q;
    assign fault_addr     = fault_addr_q;
    assign fault_cause    = fault_cause_q;

endmodule

// File: tb/tb_apb_interconnect.sv
// tb/tb_apb_interconnect.sv - directed self-checking bench for apb_interconnect
module tb_apb_interconnect;

    logic         pclk;
    logic         rst;
    logic [31:0]  paddr;
    logic         psel;
    logic         penable;
    logic [31:0]  prdata;
    logic         pready;
    logic         perr;
    logic [3:0]   s_sel;
    logic [3:0]   s_enable;
    logic [127:0] s_rdata;
    logic [3:0]   s_ready;
    logic [3:0]   s_perr;
    logic         fault_valid;
    logic         fault_overflow;
    logic [31:0]  fault_addr;
    logic [1:0]   fault_cause;
    logic         fault_clear;

    int n_vec;
    int n_err;

    apb_interconnect #(
        .TIMEOUT_CYCLES (8)
    ) dut (
        .pclk           (pclk),
        .rst            (rst),
        .paddr          (paddr),
        .psel           (psel),
        .penable        (penable),
        .prdata         (prdata),
        .pready         (pready),
        .perr           (perr),
        .s_sel          (s_sel),
        .s_enable       (s_enable),
        .s_rdata        (s_rdata),
        .s_ready        (s_ready),
        .s_perr         (s_perr),
        .fault_valid    (fault_valid),
        .fault_overflow (fault_overflow),
        .fault_addr     (fault_addr),
        .fault_cause    (fault_cause),
        .fault_clear    (fault_clear)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic check_fault(input string tag, input logic v, input logic o,
                               input logic [31:0] a, input logic [1:0] c);
        check({tag, "_fvalid"}, 32'(fault_valid), 32'(v));
        check({tag, "_fovf"},   32'(fault_overflow), 32'(o));
        check({tag, "_faddr"},  fault_addr, a);
        check({tag, "_fcause"}, 32'(fault_cause), 32'(c));
    endtask

    // IDLE cycle (master setup phase) followed by the interconnect's SETUP cycle.
    task automatic start(input logic [31:0] addr, input logic [3:0] exp_sel, input string tag);
        @(negedge pclk);
        paddr = addr; psel = 1'b1; penable = 1'b0; s_ready = '0;
        #1 check({tag, "_idle_sel"}, 32'(s_sel), 32'h0);
        @(negedge pclk);
        penable = 1'b1;
        #1;
        check({tag, "_setup_sel"}, 32'(s_sel), 32'(exp_sel));
        check({tag, "_setup_en"},  32'(s_enable), 32'h0);
        check({tag, "_setup_rdy"}, 32'(pready), 32'h0);
    endtask

    task automatic end_xfer();
        @(negedge pclk);
        psel = 1'b0; penable = 1'b0; s_ready = '0; s_perr = '0;
        #1;
    endtask

    task automatic pulse_clear();
        @(negedge pclk);
        fault_clear = 1'b1;
        @(negedge pclk);
        fault_clear = 1'b0;
        #1;
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        rst = 1'b1; psel = 1'b0; penable = 1'b0; paddr = '0;
        s_ready = '0; s_perr = '0; fault_clear = 1'b0;
        s_rdata = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'hDEAD_BEEF};

        // Reset: outputs held low even with an illegal psel&penable present
        @(negedge pclk);
        psel = 1'b1; penable = 1'b1; paddr = 32'h8000_0000;
        #1;
        check("rst_sel", 32'(s_sel), 32'h0);
        check("rst_rdy", 32'(pready), 32'h0);
        check("rst_err", 32'(perr), 32'h0);
        check("rst_rdata", prdata, 32'h0);
        check_fault("rst", 1'b0, 1'b0, 32'h0, 2'd0);
        @(negedge pclk);
        rst = 1'b0; psel = 1'b0; penable = 1'b0;

        // SRAM read, ready in first ACCESS cycle
        start(32'h8000_0010, 4'b0001, "rd");
        @(negedge pclk);
        s_ready = 4'b0001;
        #1;
        check("rd_sel", 32'(s_sel), 32'h1);
        check("rd_en", 32'(s_enable), 32'h1);
        check("rd_rdy", 32'(pready), 32'h1);
        check("rd_err", 32'(perr), 32'h0);
        check("rd_data", prdata, 32'hDEAD_BEEF);
        end_xfer();
        check("rd_nofault", 32'(fault_valid), 32'h0);

        // UART write with three wait states; paddr moves mid-ACCESS
        start(32'h1000_0000, 4'b0010, "wr");
        for (int c = 1; c <= 4; c++) begin
            @(negedge pclk);
            s_ready = (c == 4) ? 4'b0010 : 4'b0000;
            if (c == 2) paddr = 32'h8000_0000;
            #1;
            check($sformatf("wr_sel_c%0d", c), 32'(s_sel), 32'h2);
            check($sformatf("wr_en_c%0d", c), 32'(s_enable), 32'h2);
            check($sformatf("wr_rdy_c%0d", c), 32'(pready), (c == 4) ? 32'h1 : 32'h0);
        end
        check("wr_err", 32'(perr), 32'h0);
        end_xfer();

        // Unmapped access
        start(32'h3000_0000, 4'b0000, "um");
        @(negedge pclk);
        #1;
        check("um_sel", 32'(s_sel), 32'h0);
        check("um_en", 32'(s_enable), 32'h0);
        check("um_rdy", 32'(pready), 32'h1);
        check("um_err", 32'(perr), 32'h1);
        check("um_data", prdata, 32'h0);
        end_xfer();
        check_fault("um", 1'b1, 1'b0, 32'h3000_0000, 2'd0);
        pulse_clear();
        check_fault("clr1", 1'b0, 1'b0, 32'h0, 2'd0);

        // INTC never ready: times out in ACCESS cycle 9
        start(32'h2000_0000, 4'b1000, "to");
        for (int c = 1; c <= 9; c++) begin
            @(negedge pclk);
            #1;
            check($sformatf("to_rdy_c%0d", c), 32'(pready), (c == 9) ? 32'h1 : 32'h0);
            check($sformatf("to_sel_c%0d", c), 32'(s_sel), (c == 9) ? 32'h0 : 32'h8);
        end
        check("to_err", 32'(perr), 32'h1);
        check("to_en", 32'(s_enable), 32'h0);
        check("to_data", prdata, 32'h0);
        end_xfer();
        check_fault("to", 1'b1, 1'b0, 32'h2000_0000, 2'd2);

        // Ready arriving in the timeout cycle wins
        start(32'h2000_0000, 4'b1000, "tw");
        for (int c = 1; c <= 9; c++) begin
            @(negedge pclk);
            s_ready = (c == 9) ? 4'b1000 : 4'b0000;
            #1;
        end
        check("tw_rdy", 32'(pready), 32'h1);
        check("tw_err", 32'(perr), 32'h0);
        check("tw_data", prdata, 32'h3333_3333);
        check("tw_sel", 32'(s_sel), 32'h8);
        end_xfer();
        check_fault("tw", 1'b1, 1'b0, 32'h2000_0000, 2'd2);

        // Second fault while valid: overflow only
        start(32'h3000_0004, 4'b0000, "ov");
        @(negedge pclk);
        #1 check("ov_rdy", 32'(pready), 32'h1);
        end_xfer();
        check_fault("ov", 1'b1, 1'b1, 32'h2000_0000, 2'd2);
        pulse_clear();
        check_fault("clr2", 1'b0, 1'b0, 32'h0, 2'd0);

        // Protocol violation: psel&penable from IDLE
        @(negedge pclk);
        paddr = 32'h1234_5678; psel = 1'b1; penable = 1'b1;
        #1;
        check("pv_rdy", 32'(pready), 32'h1);
        check("pv_err", 32'(perr), 32'h1);
        check("pv_sel", 32'(s_sel), 32'h0);
        @(negedge pclk);
        psel = 1'b0; penable = 1'b0;
        #1 check_fault("pv", 1'b1, 1'b0, 32'h1234_5678, 2'd3);

        // Clear and a new fault in the same cycle: new fault captured
        @(negedge pclk);
        fault_clear = 1'b1; paddr = 32'h0000_ABCD; psel = 1'b1; penable = 1'b1;
        @(negedge pclk);
        fault_clear = 1'b0; psel = 1'b0; penable = 1'b0;
        #1 check_fault("cc", 1'b1, 1'b0, 32'h0000_ABCD, 2'd3);
        pulse_clear();

        // Back-to-back: SETUP directly after pready
        start(32'h8000_0020, 4'b0001, "bb");
        @(negedge pclk);
        s_ready = 4'b0001;
        #1 check("bb_rdy0", 32'(pready), 32'h1);
        @(negedge pclk);
        penable = 1'b0; paddr = 32'h1000_0004; s_ready = '0;
        #1;
        check("bb_setup_sel", 32'(s_sel), 32'h2);
        check("bb_setup_en", 32'(s_enable), 32'h0);
        check("bb_setup_rdy", 32'(pready), 32'h0);
        @(negedge pclk);
        penable = 1'b1; s_ready = 4'b0010;
        #1;
        check("bb_rdy1", 32'(pready), 32'h1);
        check("bb_en1", 32'(s_enable), 32'h2);
        check("bb_data1", prdata, 32'h1111_1111);
        end_xfer();

        // Slave error
        start(32'h8000_0100, 4'b0001, "se");
        @(negedge pclk);
        s_ready = 4'b0001; s_perr = 4'b0001;
        #1;
        check("se_rdy", 32'(pready), 32'h1);
        check("se_err", 32'(perr), 32'h1);
        end_xfer();
        check_fault("se", 1'b1, 1'b0, 32'h8000_0100, 2'd1);

        // Reset mid-ACCESS
        start(32'h8000_0000, 4'b0001, "mr");
        @(negedge pclk);
        s_ready = '0;
        #1 check("mr_en", 32'(s_enable), 32'h1);
        #1 rst = 1'b1;
        #1;
        check("mr_sel", 32'(s_sel), 32'h0);
        check("mr_en0", 32'(s_enable), 32'h0);
        check("mr_rdy", 32'(pready), 32'h0);
        check_fault("mr", 1'b0, 1'b0, 32'h0, 2'd0);
        @(negedge pclk);
        rst = 1'b0; psel = 1'b0; penable = 1'b0;
        start(32'h8000_0040, 4'b0001, "pr");
        @(negedge pclk);
        s_ready = 4'b0001;
        #1;
        check("pr_rdy", 32'(pready), 32'h1);
        check("pr_data", prdata, 32'hDEAD_BEEF);
        end_xfer();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/apb_interconnect.md
Name: apb_interconnect

Overview:
- Parametrised APB decoder/router: one upstream APB master, NUM_SLAVES downstream slaves, each selected by a base/mask address window.
- Adds what the fixed decoder lacked: an explicit SETUP/ACCESS state machine with decode latched at SETUP, a per-transfer timeout watchdog, protocol-violation detection, and a sticky fault-capture register.
- Sits between the core's load/store APB master and the SRAM/UART/system/INTC slaves.
- paddr/pdata/pwrite/pstb fan out to all slaves outside this block.

Parameters:
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, data width.
- NUM_SLAVES, 4, number of downstream slaves, 1..16.
- SLAVE_BASE, {NUM_SLAVES x ADDR_WIDTH}, packed base addresses; slave i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- SLAVE_MASK, {NUM_SLAVES x ADDR_WIDTH}, packed masks. Hit for slave i is (paddr & mask_i) == (base_i & mask_i).
- TIMEOUT_CYCLES, 255, ACCESS cycles allowed without pready; 0 disables the watchdog.

Ports:
- pclk  in  1  clock
- rst  in  1  asynchronous active-high reset
- paddr  in  ADDR_WIDTH  upstream address
- psel  in  1  upstream select
- penable  in  1  upstream enable
- prdata  out  DATA_WIDTH  read data returned to the master
- pready  out  1  transfer complete
- perr  out  1  transfer error, valid with pready
- s_sel  out  NUM_SLAVES  one-hot slave select
- s_enable  out  NUM_SLAVES  one-hot slave enable
- s_rdata  in  NUM_SLAVES*DATA_WIDTH  packed slave read data
- s_ready  in  NUM_SLAVES  slave ready
- s_perr  in  NUM_SLAVES  slave error
- fault_valid  out  1  sticky: a fault has been captured
- fault_overflow  out  1  sticky: another fault occurred while fault_valid was set
- fault_addr  out  ADDR_WIDTH  address of the first captured fault
- fault_cause  out  2  0 unmapped, 1 slave error, 2 timeout, 3 protocol violation
- fault_clear  in  1  single-cycle pulse; clears the fault register

Behaviour:
- Reset (async, while rst=1):
  - state=IDLE; latched index=0; hit flag=0; timeout counter=0.
  - All fault_* outputs 0.
  - Combinational outputs held at reset value: s_sel=0, s_enable=0, pready=0, perr=0, prdata=0.
- Decode:
  - Combinational on paddr.
  - Lowest-index matching slave wins on overlap.
  - No match means unmapped.
- FSM, states IDLE, SETUP, ACCESS:
  - IDLE: psel & !penable -> SETUP. psel & penable -> protocol violation.
  - SETUP: lasts one cycle. s_sel[idx]=1 combinationally from the live decode; s_enable=0; pready=0. At the clock edge, latch idx and hit, clear the counter, go to ACCESS.
  - ACCESS: s_sel[idx_q]=1 and s_enable[idx_q]=penable, using the latched index. paddr changes are ignored.
  - Normal completion: pready=s_ready[idx_q], perr=s_perr[idx_q], prdata=s_rdata[idx_q]. On pready, psel ? SETUP (back-to-back) : IDLE.
  - Unmapped in ACCESS: no s_sel/s_enable; pready=1, perr=1, prdata=0, zero wait states; capture cause 0.
  - Slave error (ready & s_perr): capture cause 1.
- Timeout:
  - Counter increments each ACCESS cycle with pready=0. Width is clog2(TIMEOUT_CYCLES+1), saturating.
  - When counter == TIMEOUT_CYCLES (and TIMEOUT_CYCLES != 0): force pready=1, perr=1, prdata=0, drop s_sel/s_enable to 0; capture cause 2.
  - A slave that never responds therefore completes in ACCESS cycle TIMEOUT_CYCLES+1.
  - If s_ready arrives in that same cycle, the slave response wins and no timeout is recorded.
- Protocol violation:
  - Triggers: psel&penable seen in IDLE, or psel dropped in ACCESS before pready.
  - Response: pready=1, perr=1 for that cycle; state->IDLE; no slave selected; capture cause 3.
- Fault capture:
  - On a fault with fault_valid=0: load fault_addr (the latched address; paddr for protocol violations) and fault_cause, and set fault_valid.
  - On a fault with fault_valid=1: set fault_overflow only; the first record is kept.
  - fault_clear clears valid, overflow, addr and cause. If a fault occurs in the same cycle, the new fault is captured and clear takes effect first.
- Reset mid-transfer: outputs drop immediately; the slave sees sel fall.
- Width rules: prdata is selected by the index, not OR-reduced; non-selected slave data is ignored.

Decomposition:
- Package apb_pkg holds:
  - fault_cause_t enum: FAULT_UNMAPPED=0, FAULT_SLVERR=1, FAULT_TIMEOUT=2, FAULT_PROTO=3.
  - apb_state_t enum: IDLE, SETUP, ACCESS.
  - Default memory-map constants: SRAM 0x80000000/mask 0x80000000; UART 0x10000000/0xFE000000; SYSTEM 0x00000000/0xFFFF0000; INTC 0x20000000/0xFFFFFFFF.
- Sub-module apb_addr_decode: combinational base/mask match plus priority encoder, outputting hit and index.

Test Plan:
- Default map, read 0x80000010; SRAM s_ready=1 in the first ACCESS cycle, s_rdata[0]=0xDEADBEEF -> s_sel[0] in SETUP+ACCESS, prdata=0xDEADBEEF, pready=1, perr=0, no fault.
- Write 0x10000000; UART holds s_ready low 3 cycles -> s_enable[1] held 4 ACCESS cycles, pready on the 4th, paddr change mid-ACCESS has no effect.
- Access 0x30000000 -> no s_sel, pready=perr=1 in the first ACCESS cycle, fault_valid=1, fault_addr=0x30000000, cause=0.
- TIMEOUT_CYCLES=8; INTC never ready -> pready=perr=1 in ACCESS cycle 9, s_sel dropped, cause=2. A second unmapped access -> fault_overflow=1, fault_addr unchanged. fault_clear -> all fault outputs 0.
- psel&penable asserted from IDLE -> same-cycle pready=perr=1, cause=3. Back-to-back transfers with psel held -> SETUP immediately after pready, no IDLE cycle.
- Assert rst mid-ACCESS -> s_sel, s_enable, pready, fault_* go 0 before the next pclk edge; FSM returns to IDLE.
